// File: rtl/rs232_uart_core.sv
// 8N1 RS-232 port with 16x oversampled receiver and FIFOs on both directions.
// Latency: TX line falls within DIV+2 clocks of first push; RX byte visible <=3 clocks after stop centre.
// Backpressure: writes to a full TX FIFO and RX bytes arriving at a full RX FIFO are dropped.

// Generic FIFO with registered count and first-word fall-through head.
// Latency: flags update the cycle after the push/pop that changes them.
// Backpressure: push ignored when full (even with a same-cycle pop), pop ignored when empty.
module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < (AW+1)'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

// PicoBlaze-facing UART core: TX FIFO -> serialiser, deserialiser -> RX FIFO.
// Latency: see file header; rx_data_out advances one cycle after an ack.
// Backpressure: tx_buffer_full signals a full TX FIFO; RX overflow loses the newest byte.
module rs232_uart_core #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data_in,
  input  logic       write_tx_data,
  output logic       tx_buffer_full,
  output logic [7:0] rx_data_out,
  input  logic       read_rx_data_ack,
  output logic       rx_data_present,
  output logic       rs232_tx,
  input  logic       rs232_rx
);
  localparam int DIV = CLK_FREQ / (16 * BAUD);
  localparam int BW  = $clog2(DIV + 1);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [BW-1:0] baud_cnt;
  logic          tick;

  logic [7:0] tx_head;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_pop;
  logic [1:0] tx_state;
  logic [3:0] tx_tick;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;

  logic       rx_meta;
  logic       rx_sync;
  logic       rx_prev;
  logic       rx_fall;
  logic [1:0] rx_state;
  logic [3:0] rx_tick;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift;
  logic       rx_push;
  logic [7:0] rx_head;
  logic       rx_full;
  logic       rx_empty;

  assign tick = (baud_cnt == BW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) baud_cnt <= '0;
    else        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (write_tx_data),
    .push_dat (tx_data_in),
    .pop      (tx_pop),
    .head     (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  assign tx_buffer_full = tx_full;

  // A new byte is taken either from idle or at the end of the stop bit, so frames run back to back.
  assign tx_pop = tick && !tx_empty &&
                  ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_tick == 4'd15)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_tick  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      rs232_tx <= 1'b1;
    end else if (tick) begin
      case (tx_state)
        TX_IDLE: begin
          tx_tick <= '0;
          if (tx_pop) begin
            tx_state <= TX_START;
            tx_shift <= tx_head;
            rs232_tx <= 1'b0;
          end
        end
        TX_START: begin
          tx_tick <= tx_tick + 1'b1;
          if (tx_tick == 4'd15) begin
            tx_state <= TX_DATA;
            tx_bit   <= '0;
            rs232_tx <= tx_shift[0];
          end
        end
        TX_DATA: begin
          tx_tick <= tx_tick + 1'b1;
          if (tx_tick == 4'd15) begin
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              rs232_tx <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 1'b1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              rs232_tx <= tx_shift[1];
            end
          end
        end
        TX_STOP: begin
          tx_tick <= tx_tick + 1'b1;
          if (tx_tick == 4'd15) begin
            if (tx_pop) begin
              tx_state <= TX_START;
              tx_shift <= tx_head;
              rs232_tx <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rs232_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev && !rx_sync;
  assign rx_push = tick && (rx_state == RX_STOP) && (rx_tick == 4'd15) && rx_sync && !rx_full;

  // Start is qualified at its centre (tick 8); later samples land 16 ticks apart on bit centres.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= RX_IDLE;
      rx_tick  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_tick  <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (rx_tick == 4'd7) begin
              rx_tick  <= '0;
              rx_bit   <= '0;
              rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick <= rx_tick + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            rx_tick <= rx_tick + 1'b1;
            if (rx_tick == 4'd15) begin
              rx_shift <= {rx_sync, rx_shift[7:1]};
              rx_bit   <= rx_bit + 1'b1;
              if (rx_bit == 3'd7) rx_state <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            rx_tick <= rx_tick + 1'b1;
            if (rx_tick == 4'd15) rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (rx_push),
    .push_dat (rx_shift),
    .pop      (read_rx_data_ack),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  assign rx_data_present = !rx_empty;
  assign rx_data_out     = rx_empty ? 8'h00 : rx_head;
endmodule

// File: tb/tb_rs232_uart_core.sv
// Bench for rs232_uart_core: line-level frame decoder for TX, frame generator for RX, queue models.
`timescale 1ns/1ps
module tb_rs232_uart_core;
  localparam int CLK_FREQ   = 9_216_007;
  localparam int BAUD       = 115200;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = CLK_FREQ / (16 * BAUD);
  localparam int BIT        = 16 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] tx_data_in = 8'h00;
  logic       write_tx_data = 1'b0;
  logic       tx_buffer_full;
  logic [7:0] rx_data_out;
  logic       read_rx_data_ack = 1'b0;
  logic       rx_data_present;
  logic       rs232_tx;
  logic       rs232_rx = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rs232_uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .tx_data_in       (tx_data_in),
    .write_tx_data    (write_tx_data),
    .tx_buffer_full   (tx_buffer_full),
    .rx_data_out      (rx_data_out),
    .read_rx_data_ack (read_rx_data_ack),
    .rx_data_present  (rx_data_present),
    .rs232_tx         (rs232_tx),
    .rs232_rx         (rs232_rx)
  );

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data_in    = b;
    write_tx_data = 1'b1;
    @(negedge clk);
    write_tx_data = 1'b0;
  endtask

  // Waits for a start bit, then samples every cycle of the 10-bit frame.
  task automatic capture_tx(input int max_wait, output logic [9:0] bits, output int waited,
                            output bit stable);
    bits = '1;
    stable = 1'b1;
    waited = 0;
    while (rs232_tx !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    if (rs232_tx !== 1'b0) begin
      stable = 1'b0;
      return;
    end
    bits[0] = 1'b0;
    for (int cyc = 1; cyc < 10 * BIT; cyc++) begin
      @(negedge clk);
      if (cyc % BIT == 1) bits[cyc / BIT] = rs232_tx;
      else if ((cyc % BIT) >= 2 && (cyc % BIT) <= BIT - 2 && rs232_tx !== bits[cyc / BIT])
        stable = 1'b0;
    end
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (rs232_tx !== 1'b1) lows++;
    end
  endtask

  task automatic send_rx_body(input logic [7:0] b);
    logic [8:0] f;
    f = {b, 1'b0};
    for (int k = 0; k < 9; k++) begin
      rs232_rx = f[k];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    send_rx_body(b);
    rs232_rx = stop;
    repeat (BIT) @(negedge clk);
    rs232_rx = 1'b1;
  endtask

  task automatic ack_rx();
    read_rx_data_ack = 1'b1;
    @(negedge clk);
    read_rx_data_ack = 1'b0;
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tx_data_in       = 8'($urandom);
      write_tx_data    = 1'($urandom);
      read_rx_data_ack = 1'($urandom);
      rs232_rx         = 1'($urandom);
      #1;
      checks++;
      if ({rs232_tx, tx_buffer_full, rx_data_present, rx_data_out} !== {3'b100, 8'h00}) begin
        failures++;
        $display("FAIL reset_hold got tx=%b full=%b present=%b data=%h exp tx=1 full=0 present=0 data=00",
                 rs232_tx, tx_buffer_full, rx_data_present, rx_data_out);
      end
    end
    @(negedge clk);
    write_tx_data = 1'b0;
    read_rx_data_ack = 1'b0;
    rs232_rx = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    count_low(20 * BIT, lows);
    checks++;
    if (lows != 0) begin
      failures++;
      $display("FAIL reset_idle_line got low_cycles=%0d exp 0", lows);
    end
    checks++;
    if (tx_buffer_full !== 1'b0 || rx_data_present !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got full=%b present=%b exp 0 0", tx_buffer_full, rx_data_present);
    end
  endtask

  task automatic test_tx_byte();
    logic [9:0] bits;
    int waited, lows;
    bit stable;
    write_byte(8'hA5);
    capture_tx(DIV + 4, bits, waited, stable);
    checks++;
    if (waited > DIV + 2) begin
      failures++;
      $display("FAIL tx_latency got %0d clocks exp <= %0d", waited, DIV + 2);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL tx_bit_timing got unstable/missing frame exp %0d clocks per bit", BIT);
    end
    checks++;
    if (bits !== {1'b1, 8'hA5, 1'b0}) begin
      failures++;
      $display("FAIL tx_a5_pattern got %b exp %b", bits, {1'b1, 8'hA5, 1'b0});
    end
    count_low(2 * BIT, lows);
    checks++;
    if (lows != 0) begin
      failures++;
      $display("FAIL tx_after_idle got low_cycles=%0d exp 0", lows);
    end
  endtask

  task automatic test_tx_random();
    logic [7:0] exp_q[$];
    logic [9:0] got[4];
    bit stab[4];
    int waits[4];
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          write_byte(b);
          exp_q.push_back(b);
        end
      end
      begin
        for (int i = 0; i < 4; i++) capture_tx(3 * BIT, got[i], waits[i], stab[i]);
      end
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (!stab[i] || got[i] !== {1'b1, exp_q[i], 1'b0}) begin
        failures++;
        $display("FAIL tx_random[%0d] got %b stable=%0d exp %b", i, got[i], stab[i], {1'b1, exp_q[i], 1'b0});
      end
    end
  endtask

  task automatic test_tx_full();
    logic [7:0] exp_q[$];
    logic [9:0] got[17];
    bit stab[17];
    int waits[17];
    int lows;
    logic [7:0] b0;
    b0 = 8'($urandom);
    exp_q.push_back(b0);
    write_byte(b0);
    fork
      begin
        int w;
        w = 0;
        while (rs232_tx !== 1'b0 && w < 2 * BIT) begin
          @(negedge clk);
          w++;
        end
        for (int i = 0; i < 17; i++) begin
          @(negedge clk);
          if (i > 0) begin
            checks++;
            if (tx_buffer_full !== (i >= FIFO_DEPTH)) begin
              failures++;
              $display("FAIL tx_full_flag after %0d writes got %b exp %b", i, tx_buffer_full, (i >= FIFO_DEPTH));
            end
          end
          tx_data_in    = i[7:0];
          write_tx_data = 1'b1;
          if (exp_q.size() < FIFO_DEPTH + 1) exp_q.push_back(i[7:0]);
        end
        @(negedge clk);
        write_tx_data = 1'b0;
        checks++;
        if (tx_buffer_full !== 1'b1) begin
          failures++;
          $display("FAIL tx_full_after_17th got %b exp 1", tx_buffer_full);
        end
      end
      begin
        for (int i = 0; i < 17; i++) capture_tx(2 * BIT, got[i], waits[i], stab[i]);
      end
    join
    for (int i = 0; i < 17; i++) begin
      checks++;
      if (!stab[i] || got[i] !== {1'b1, exp_q[i], 1'b0}) begin
        failures++;
        $display("FAIL tx_full_frame[%0d] got %b stable=%0d exp %b", i, got[i], stab[i], {1'b1, exp_q[i], 1'b0});
      end
      if (i > 0) begin
        checks++;
        if (waits[i] > 1) begin
          failures++;
          $display("FAIL tx_back_to_back[%0d] got gap=%0d exp <= 1", i, waits[i]);
        end
      end
    end
    count_low(3 * BIT, lows);
    checks++;
    if (lows != 0) begin
      failures++;
      $display("FAIL tx_dropped_17th got low_cycles=%0d exp 0", lows);
    end
  endtask

  task automatic test_rx_byte();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    send_rx_body(8'h3C);
    rs232_rx = 1'b1;
    repeat (BIT / 2 - 6) @(negedge clk);
    checks++;
    if (rx_data_present !== 1'b0) begin
      failures++;
      $display("FAIL rx_early_present got %b exp 0", rx_data_present);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rx_data_present !== 1'b1 || rx_data_out !== 8'h3C) begin
      failures++;
      $display("FAIL rx_3c got present=%b data=%h exp present=1 data=3c", rx_data_present, rx_data_out);
    end
    repeat (BIT / 2 - 4) @(negedge clk);
    ack_rx();
    checks++;
    if (rx_data_present !== 1'b0) begin
      failures++;
      $display("FAIL rx_ack_clears got %b exp 0", rx_data_present);
    end
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_rx(b, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rx_data_present !== 1'b1 || rx_data_out !== exp_q[i]) begin
        failures++;
        $display("FAIL rx_random[%0d] got present=%b data=%h exp 1 %h", i, rx_data_present, rx_data_out, exp_q[i]);
      end
      ack_rx();
    end
    ack_rx();
    b = 8'($urandom);
    send_rx(b, 1'b1);
    checks++;
    if (rx_data_present !== 1'b1 || rx_data_out !== b) begin
      failures++;
      $display("FAIL rx_after_empty_ack got present=%b data=%h exp 1 %h", rx_data_present, rx_data_out, b);
    end
    ack_rx();
    checks++;
    if (rx_data_present !== 1'b0) begin
      failures++;
      $display("FAIL rx_drain got %b exp 0", rx_data_present);
    end
  endtask

  task automatic test_rx_errors();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    rs232_rx = 1'b0;
    repeat (BIT / 4) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (rx_data_present !== 1'b0) begin
      failures++;
      $display("FAIL rx_glitch got present=%b exp 0", rx_data_present);
    end
    send_rx(8'($urandom), 1'b0);
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (rx_data_present !== 1'b0) begin
      failures++;
      $display("FAIL rx_framing got present=%b exp 0", rx_data_present);
    end
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      b = 8'($urandom);
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(b);
      send_rx(b, 1'b1);
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      checks++;
      if (rx_data_present !== 1'b1 || rx_data_out !== exp_q[i]) begin
        failures++;
        $display("FAIL rx_overflow[%0d] got present=%b data=%h exp 1 %h", i, rx_data_present, rx_data_out, exp_q[i]);
      end
      ack_rx();
    end
    checks++;
    if (rx_data_present !== 1'b0) begin
      failures++;
      $display("FAIL rx_overflow_drain got %b exp 0", rx_data_present);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [7:0] b;
    int w, lows;
    b = 8'($urandom);
    b[3] = 1'b0;
    write_byte(b);
    write_byte(8'($urandom));
    w = 0;
    while (rs232_tx !== 1'b0 && w < 2 * BIT) begin
      @(negedge clk);
      w++;
    end
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    checks++;
    if (rs232_tx !== 1'b0) begin
      failures++;
      $display("FAIL mid_bit3_level got %b exp 0", rs232_tx);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (rs232_tx !== 1'b1 || tx_buffer_full !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_async got tx=%b full=%b exp 1 0", rs232_tx, tx_buffer_full);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    count_low(20 * BIT, lows);
    checks++;
    if (lows != 0) begin
      failures++;
      $display("FAIL mid_reset_no_frame got low_cycles=%0d exp 0", lows);
    end
  endtask

  initial begin
    test_reset();
    test_tx_byte();
    test_tx_random();
    test_tx_full();
    test_rx_byte();
    test_rx_errors();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rs232_uart_core.md
# rs232_uart_core

Byte-oriented RS-232 serial port for the PicoBlaze audio-recorder controller: 8N1 framing, 16× oversampled receiver, and 16-entry transmit and receive FIFOs. The PicoBlaze writes bytes through the write-strobe decode for port 03h and reads them through port 02h. Status is read on ports 04h (`rx_data_present`) and 05h (`tx_buffer_full`). The block runs on the single system clock supplied by the RAM interface.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 115200: line rate.
- `FIFO_DEPTH`, 16: entries per FIFO (power of two).
- `clk` in 1: system clock, rising-edge.
- `reset` in 1: one clock; reset is asynchronous and active-low (`reset`=0 resets).
- `tx_data_in` in 8: byte to transmit.
- `write_tx_data` in 1: push `tx_data_in` into TX FIFO (one push per high cycle).
- `tx_buffer_full` out 1: TX FIFO holds `FIFO_DEPTH` entries.
- `rx_data_out` out 8: head of RX FIFO (first-word fall-through).
- `read_rx_data_ack` in 1: pop RX FIFO head (one pop per high cycle).
- `rx_data_present` out 1: RX FIFO not empty.
- `rs232_tx` out 1: serial output, idle high.
- `rs232_rx` in 1: serial input, asynchronous.

## Operation
- **Baud tick:** a single-cycle enable every `DIV = CLK_FREQ/(16*BAUD)` clocks, with integer truncation. The default is 54. One bit time is 16 ticks (864 clocks at the defaults).
- **TX FIFO push:**
  - A push with `write_tx_data`=1 is accepted if the registered count is less than `FIFO_DEPTH`.
  - A write while full is dropped silently, even if a pop occurs in the same cycle.
- **Transmitter states:** IDLE → START → DATA(8) → STOP → IDLE.
  - In IDLE with the FIFO not empty, the transmitter pops the head on the next baud tick and enters START.
  - START drives 0 for 16 ticks.
  - DATA sends bits 0..7, LSB first, 16 ticks each.
  - STOP drives 1 for 16 ticks.
  - From STOP it returns to IDLE, or goes straight to START if the FIFO is non-empty, giving back-to-back frames with no extra idle.
- **Receiver:**
  - `rs232_rx` passes through a 2-flop synchronizer.
  - States: IDLE → START → DATA → STOP.
  - A falling edge in IDLE enters START. At tick 8 of START the line is sampled; if it is 1 (a glitch), return to IDLE.
  - Each data bit is sampled at the 16-tick bit centre, LSB first.
  - At the stop-bit centre:
    - 1 → the byte is pushed to the RX FIFO.
    - 0 → framing error; the byte is discarded. Then return to IDLE.
- **RX FIFO:**
  - The push is dropped when full (overflow loses the newest byte).
  - `read_rx_data_ack` pops the head; an ack while empty is ignored.
  - Push and pop in the same cycle are both performed when the FIFO is non-empty and not full.
- **Pointer and count width:** pointers are log2(`FIFO_DEPTH`) bits and wrap modulo the depth. Counts are log2(`FIFO_DEPTH`)+1 bits.

## Timing
- **Reset values:**
  - `rs232_tx`=1, `tx_buffer_full`=0, `rx_data_present`=0, `rx_data_out`=00h.
  - Both FIFOs empty, both FSMs IDLE, baud counter 0.
- **Reset mid-frame:** the frame is abandoned and the line returns high asynchronously. No partial byte enters the RX FIFO.
- **Flag latency:** `tx_buffer_full` and `rx_data_present` are registered and update the cycle after the push or pop that changes them.
- **Read data:** `rx_data_out` is valid whenever `rx_data_present`=1 and advances one cycle after an ack.
- **TX latency:** the first push into an idle transmitter makes `rs232_tx` fall within `DIV`+2 clocks.
- **RX latency:** `rx_data_present` rises no more than 3 clocks after the stop-bit centre sample (2 synchronizer clocks plus 1 push).

## Test plan
- **Reset:** hold `reset`=0, apply stimulus on all inputs, then release. → `rs232_tx`=1, both flags 0, no frame emitted for 20 bit times.
- **TX byte:** write A5h once. → the line shows 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each 864±1 clocks, then stays high.
- **TX full:** write 17 bytes 00h..10h in consecutive cycles.
  - `tx_buffer_full` rises after the 16th write.
  - The 17th (10h) is dropped.
  - The line carries 00h..0Fh back-to-back.
- **RX byte:** drive a 3Ch frame at 115200 baud. → `rx_data_present`=1 and `rx_data_out`=3Ch. Ack once → present returns to 0 the next cycle.
- **RX errors:**
  - A 200-clock low glitch → no byte.
  - A frame with stop bit 0 → no byte.
  - 17 frames without ack → the first 16 are retained in order.
- **Reset mid-transmit:** pulse `reset` low during bit 3 of a frame. → `rs232_tx` is high immediately, the FIFO is empty, and no further frame is sent.
